// File: rtl/trace_packetizer_pkg.sv
// rtl/trace_packetizer_pkg.sv - shared widths, trace item layout and flush FSM states
package trace_packetizer_pkg;

    localparam int RISC_V_INSTRUCTION_WIDTH = 32;
    localparam int TRACE_PC_WIDTH           = 64;
    localparam int TRACE_ITEM_WIDTH         = TRACE_PC_WIDTH + RISC_V_INSTRUCTION_WIDTH;

    typedef struct packed {
        logic [TRACE_PC_WIDTH-1:0]           pc;
        logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr;
    } trace_item_t;

    typedef enum logic {
        FLUSH_IDLE,
        FLUSH_ACTIVE
    } flush_state_t;

    // Saturating 32-bit increment used by the overflow counter.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/trace_packetizer_if.sv
// rtl/trace_packetizer_if.sv - stream bundle carrying packetized trace beats
interface trace_packetizer_if
    import trace_packetizer_pkg::*;
#(
    parameter int DATA_WIDTH = TRACE_ITEM_WIDTH
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous first-word-fall-through FIFO with level counter
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic             do_wr;
    logic             do_rd;

    // A write into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(do_wr);
            rd_ptr  <= rd_ptr + AW'(do_rd);
            level_q <= level_q + LW'(do_wr) - LW'(do_rd);
        end
    end
endmodule

// File: rtl/trace_packetizer.sv
// rtl/trace_packetizer.sv - buffers kept trace items and emits them as framed stream packets
module trace_packetizer
    import trace_packetizer_pkg::*;
#(
    parameter int FIFO_DEPTH       = 16,
    parameter int ITEMS_PER_PACKET = 8,
    parameter int PC_WIDTH         = TRACE_PC_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                pc_valid,
    input  logic [PC_WIDTH-1:0]                 pc,
    input  logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr,
    input  logic                                drop_instr,
    input  logic                                flush,
    trace_packetizer_if.master                  m_axis,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
    output logic [31:0]                         overflow_count
);
    localparam int ITEM_W  = PC_WIDTH + RISC_V_INSTRUCTION_WIDTH;
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BEAT_W  = (ITEMS_PER_PACKET > 1) ? $clog2(ITEMS_PER_PACKET) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(ITEMS_PER_PACKET - 1);

    logic               push;
    logic               pop;
    logic               wr_en;
    logic               fifo_full;
    logic               fifo_empty;
    logic               tvalid;
    logic               tlast;
    logic               flush_tlast;
    logic [ITEM_W-1:0]  head;
    logic [LEVEL_W-1:0] level;
    logic [LEVEL_W-1:0] level_after;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [LEVEL_W-1:0] flush_remaining;
    flush_state_t       flush_state;

    assign push  = pc_valid & ~drop_instr;
    assign pop   = tvalid & m_axis.tready;
    assign wr_en = push & (~fifo_full | pop);

    trace_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ITEM_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data ({pc, instr}),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .level   (level)
    );

    // Framing is derived only from registered state, so it cannot move while a beat stalls.
    assign tvalid      = ~fifo_empty;
    assign flush_tlast = (flush_state == FLUSH_ACTIVE) && (flush_remaining == LEVEL_W'(1));
    assign tlast       = (beat_cnt == BEAT_LAST) | flush_tlast;
    assign level_after = level - LEVEL_W'(pop);

    assign m_axis.tvalid = tvalid;
    assign m_axis.tdata  = head;
    assign m_axis.tlast  = tlast;
    assign fifo_level    = level;

    // Beat position within the packet; any tlast beat (natural or flush) starts a new packet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= tlast ? '0 : beat_cnt + 1'b1;
        end
    end

    // Flush FSM: snapshot the items queued at the request and close the packet after the last of them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_state     <= FLUSH_IDLE;
            flush_remaining <= '0;
        end else begin
            case (flush_state)
                FLUSH_IDLE: begin
                    if (flush && (level_after != '0)) begin
                        flush_remaining <= level_after;
                        flush_state     <= FLUSH_ACTIVE;
                    end
                end
                FLUSH_ACTIVE: begin
                    if (pop) begin
                        flush_remaining <= flush_remaining - 1'b1;
                        if (flush_remaining == LEVEL_W'(1)) begin
                            flush_state <= FLUSH_IDLE;
                        end
                    end
                end
                default: flush_state <= FLUSH_IDLE;
            endcase
        end
    end

    // Count items discarded because the FIFO was full with no pop to make room.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_count <= '0;
        end else if (push && fifo_full && !pop) begin
            overflow_count <= sat_inc32(overflow_count);
        end
    end
endmodule

// File: tb/tb_trace_packetizer.sv
// tb/tb_trace_packetizer.sv - directed self-checking bench for trace_packetizer
module tb_trace_packetizer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_valid = 1'b0;
    logic [63:0] pc = '0;
    logic [31:0] instr = '0;
    logic        drop_instr = 1'b0;
    logic        flush = 1'b0;
    logic        tready = 1'b0;
    logic [4:0]  fifo_level;
    logic [31:0] overflow_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [95:0] beat_data [$];
    bit          beat_last [$];

    trace_packetizer_if #(.DATA_WIDTH(96)) m_axis ();
    assign m_axis.tready = tready;

    trace_packetizer #(
        .FIFO_DEPTH       (16),
        .ITEMS_PER_PACKET (8),
        .PC_WIDTH         (64)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_valid       (pc_valid),
        .pc             (pc),
        .instr          (instr),
        .drop_instr     (drop_instr),
        .flush          (flush),
        .m_axis         (m_axis),
        .fifo_level     (fifo_level),
        .overflow_count (overflow_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && m_axis.tvalid && m_axis.tready) begin
            beat_data.push_back(m_axis.tdata);
            beat_last.push_back(m_axis.tlast);
        end
    end

    function automatic logic [95:0] mk(input logic [63:0] base, input int i);
        logic [63:0] p;
        p = base + 64'(4 * i);
        return {p, 32'h1300_0000 + 32'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        pc_valid   = 1'b0;
        drop_instr = 1'b0;
        flush      = 1'b0;
        tready     = 1'b0;
        rst_n      = 1'b0;
        tick();
        rst_n = 1'b1;
        beat_data.delete();
        beat_last.delete();
    endtask

    task automatic push_item(input logic [95:0] d);
        pc_valid   = 1'b1;
        drop_instr = 1'b0;
        pc         = d[95:32];
        instr      = d[31:0];
        tick();
        pc_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        for (int c = 0; c < 300 && beat_data.size() < n; c++) tick();
        tick();
        tick();
    endtask

    task automatic check_beats(input string name, input logic [63:0] base, input int n,
                               input int last_a, input int last_b);
        n_tests++;
        if (beat_data.size() !== n) begin
            n_fail++;
            $display("FAIL %s_count: got %0d beats, expected %0d", name, beat_data.size(), n);
        end
        for (int i = 0; i < n; i++) begin
            n_tests++;
            if (i >= beat_data.size()) begin
                n_fail++;
                $display("FAIL %s_beat%0d: missing, expected data %h", name, i, mk(base, i));
            end else if (beat_data[i] !== mk(base, i) ||
                         beat_last[i] !== ((i == last_a) || (i == last_b))) begin
                n_fail++;
                $display("FAIL %s_beat%0d: got data %h last %0d, expected data %h last %0d",
                         name, i, beat_data[i], beat_last[i], mk(base, i),
                         (i == last_a) || (i == last_b));
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (m_axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b, expected 0", m_axis.tvalid); end
        n_tests++;
        if (m_axis.tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b, expected 0", m_axis.tlast); end
        n_tests++;
        if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d, expected 0", fifo_level); end
        n_tests++;
        if (overflow_count !== 32'd0) begin n_fail++; $display("FAIL reset_overflow: got %0d, expected 0", overflow_count); end
    endtask

    task automatic test_stream();
        do_reset();
        tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_item(mk(64'h1000, i));
            if (i == 0) begin
                n_tests++;
                if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== mk(64'h1000, 0)) begin
                    n_fail++;
                    $display("FAIL stream_latency: got tvalid %b data %h, expected 1 %h",
                             m_axis.tvalid, m_axis.tdata, mk(64'h1000, 0));
                end
            end
        end
        wait_beats(10);
        check_beats("stream", 64'h1000, 10, 7, -1);
    endtask

    task automatic test_drop();
        do_reset();
        tready     = 1'b1;
        pc_valid   = 1'b1;
        drop_instr = 1'b1;
        pc         = 64'h1234;
        instr      = 32'h13;
        for (int i = 0; i < 20; i++) tick();
        pc_valid   = 1'b0;
        drop_instr = 1'b0;
        tick();
        n_tests++;
        if (beat_data.size() !== 0) begin n_fail++; $display("FAIL drop_beats: got %0d, expected 0", beat_data.size()); end
        n_tests++;
        if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL drop_level: got %0d, expected 0", fifo_level); end
        n_tests++;
        if (overflow_count !== 32'd0) begin n_fail++; $display("FAIL drop_overflow: got %0d, expected 0", overflow_count); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 20; i++) push_item(mk(64'h2000, i));
        n_tests++;
        if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL full_level: got %0d, expected 16", fifo_level); end
        n_tests++;
        if (overflow_count !== 32'd4) begin n_fail++; $display("FAIL full_overflow: got %0d, expected 4", overflow_count); end
        tready = 1'b1;
        wait_beats(16);
        check_beats("full", 64'h2000, 16, 7, 15);
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) push_item(mk(64'h3000, i));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 3; i < 5; i++) begin
            push_item(mk(64'h3000, i));
            n_tests++;
            if (m_axis.tdata !== mk(64'h3000, 0) || m_axis.tlast !== 1'b0 || m_axis.tvalid !== 1'b1) begin
                n_fail++;
                $display("FAIL flush_stall%0d: got valid %b data %h last %b, expected 1 %h 0",
                         i, m_axis.tvalid, m_axis.tdata, m_axis.tlast, mk(64'h3000, 0));
            end
        end
        n_tests++;
        if (fifo_level !== 5'd5) begin n_fail++; $display("FAIL flush_level: got %0d, expected 5", fifo_level); end
        tready = 1'b1;
        wait_beats(5);
        check_beats("flush", 64'h3000, 5, 2, -1);
    endtask

    task automatic test_flush_empty();
        do_reset();
        tready = 1'b1;
        flush  = 1'b1;
        tick();
        flush = 1'b0;
        n_tests++;
        if (m_axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_tvalid: got %b, expected 0", m_axis.tvalid); end
        for (int i = 0; i < 8; i++) push_item(mk(64'h4000, i));
        wait_beats(8);
        check_beats("flush_empty", 64'h4000, 8, 7, -1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 18; i++) push_item(mk(64'h5000, i));
        n_tests++;
        if (overflow_count !== 32'd2) begin n_fail++; $display("FAIL mid_overflow_pre: got %0d, expected 2", overflow_count); end
        tready = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        tready = 1'b0;
        n_tests++;
        if (fifo_level !== 5'd5) begin n_fail++; $display("FAIL mid_level_pre: got %0d, expected 5", fifo_level); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_tests++;
        if (m_axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_tvalid: got %b, expected 0", m_axis.tvalid); end
        n_tests++;
        if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL mid_level: got %0d, expected 0", fifo_level); end
        n_tests++;
        if (overflow_count !== 32'd0) begin n_fail++; $display("FAIL mid_overflow: got %0d, expected 0", overflow_count); end
        beat_data.delete();
        beat_last.delete();
        tready = 1'b1;
        for (int i = 0; i < 8; i++) push_item(mk(64'h6000, i));
        wait_beats(8);
        check_beats("mid_after", 64'h6000, 8, 7, -1);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_drop();
        test_full();
        test_flush();
        test_flush_empty();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/trace_packetizer.md
Name: trace_packetizer

Overview:
- Sits directly downstream of the trace filter.
- Captures every trace item the filter keeps: a pair {pc, instr} where pc_valid=1 and drop_instr=0.
- Buffers items in a synchronous FIFO and emits them as AXI4-Stream beats toward the DMA/host.
- Packets hold ITEMS_PER_PACKET beats; a flush request closes a partial packet early. Items lost to overflow are counted.

Parameters:
- FIFO_DEPTH, 16, number of trace items buffered; must be a power of two, at least 2.
- ITEMS_PER_PACKET, 8, beats per AXIS packet before tlast; range 1..1024.
- PC_WIDTH, 64, width of the program counter field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- pc_valid  in  1  the core retired an instruction this cycle.
- pc  in  PC_WIDTH  pc of the retired instruction.
- instr  in  RISC_V_INSTRUCTION_WIDTH  retired instruction word.
- drop_instr  in  1  from the trace filter; 1 = do not record this item.
- flush  in  1  single-cycle request to terminate the current packet.
- m_axis_tdata  out  TRACE_ITEM_WIDTH  {pc, instr}, with pc in the MSBs.
- m_axis_tvalid  out  1  head item is valid.
- m_axis_tready  in  1  downstream accepts.
- m_axis_tlast  out  1  last beat of the packet.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current number of buffered items.
- overflow_count  out  32  items lost because the FIFO was full; saturates at 2^32-1.

Behaviour:
- Reset values:
  - m_axis_tvalid=0, m_axis_tlast=0, fifo_level=0, overflow_count=0.
  - Packet beat counter=0, flush state=IDLE.
  - m_axis_tdata is don't-care while tvalid=0.
- Push condition: push = pc_valid & ~drop_instr. The item is written on that clk edge. Latency from input to tvalid is 1 cycle (FWFT).
- Pop condition: pop = m_axis_tvalid & m_axis_tready.
- Output: m_axis_tvalid = (level != 0). tdata is the head entry.
- AXIS stability: once tvalid=1 and tready=0, tdata and tlast hold until the beat transfers. A push arriving during a stall never alters the head or tlast.
- Full FIFO:
  - A push when level==FIFO_DEPTH and no pop occurs that cycle is discarded and overflow_count increments.
  - Push with pop on a full FIFO is accepted; level is unchanged.
- Empty FIFO: push and pop on the same cycle cannot occur, because tvalid=0 so there is no pop. The level update is level + push - pop.
- Beat counter:
  - Increments on each pop.
  - tlast = (beat_cnt == ITEMS_PER_PACKET-1) | flush_tlast.
  - When a beat with tlast=1 transfers, beat_cnt goes to 0.
- Flush FSM, states IDLE and FLUSHING:
  - IDLE + flush=1:
    - level_after = level - pop.
    - If level_after == 0, flush is ignored (stay IDLE).
    - Otherwise load flush_remaining = level_after and go to FLUSHING.
  - FLUSHING:
    - flush_remaining decrements on each pop. Pushes do not affect it.
    - flush_tlast = (flush_remaining == 1).
    - When the beat with flush_remaining==1 transfers, go to IDLE and set beat_cnt=0.
    - If a natural tlast occurs first, beat_cnt resets and FLUSHING continues.
  - flush asserted while in FLUSHING is ignored.
- Reset mid-operation: FIFO contents are discarded, pointers are zeroed, overflow_count clears, and the FSM goes to IDLE. On the next cycle tvalid=0.
- Pointers wrap modulo FIFO_DEPTH. Level is held in a separate counter of width $clog2(FIFO_DEPTH)+1.

Decomposition:
- continuous_monitoring_system_pkg gains:
  - TRACE_ITEM_WIDTH = PC_WIDTH + RISC_V_INSTRUCTION_WIDTH.
  - typedef trace_item_t: packed struct {pc, instr}.
  - typedef flush_state_t: enum {FLUSH_IDLE, FLUSH_ACTIVE}.
- Sub-module trace_fifo:
  - Synchronous, FWFT, parameterised depth and width.
  - Ports: wr_en, wr_data, full, rd_en, rd_data, empty, level.
  - The packetizer holds the beat counter, the flush FSM and the overflow counter.

Test Plan:
- Ten consecutive cycles with pc_valid=1, drop_instr=0, pc=0x1000+4i, m_axis_tready=1 -> 10 beats in order. tlast on beats 8 and 10 is 1 only on beat 8; beat 10 has no tlast. Beat 1 arrives one cycle after the first push.
- pc_valid=1 with drop_instr=1 for 20 cycles -> no beats, fifo_level=0, overflow_count=0.
- tready=0, push 20 items -> fifo_level=16 and overflow_count=4. Raise tready -> the first 16 pcs come out unchanged and in order. tlast is on beats 8 and 16.
- 3 items buffered with tready=0, pulse flush, push 2 more, then tready=1 -> tlast on beat 3. The next 2 beats form a new packet with no tlast. tdata and tlast are stable throughout the stall.
- flush with an empty FIFO -> stays IDLE. The next 8 pushes give tlast on beat 8 only.
- rst_n=0 for 1 cycle with 5 items buffered and overflow_count=2 -> next cycle tvalid=0, fifo_level=0, overflow_count=0. A subsequent push appears as beat 1 of a new packet.
